// File: rtl/svc_axil_mem_tester.sv
// AXI-lite memory tester: writes seed^index to a word range, reads it back and counts mismatches.
// Define SVC_AXIL_MEM_TESTER_ERR_CAPTURE_EN to record the first failing address and data.
module svc_axil_mem_tester #(
  parameter int AXIL_ADDR_WIDTH = 16,
  parameter int AXIL_DATA_WIDTH = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [AXIL_ADDR_WIDTH-1:0]   base_addr,
  input  logic [CNT_WIDTH-1:0]         num_words,
  input  logic [AXIL_DATA_WIDTH-1:0]   seed,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [CNT_WIDTH-1:0]         err_cnt,
  output logic [AXIL_ADDR_WIDTH-1:0]   err_addr,
  output logic [AXIL_DATA_WIDTH-1:0]   err_data,
  output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic                         m_axil_awvalid,
  input  logic                         m_axil_awready,
  output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                         m_axil_wvalid,
  input  logic                         m_axil_wready,
  input  logic [1:0]                   m_axil_bresp,
  input  logic                         m_axil_bvalid,
  output logic                         m_axil_bready,
  output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic                         m_axil_arvalid,
  input  logic                         m_axil_arready,
  input  logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]                   m_axil_rresp,
  input  logic                         m_axil_rvalid,
  output logic                         m_axil_rready
);

  localparam int AW = AXIL_ADDR_WIDTH;
  localparam int DW = AXIL_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int XW = (CNT_WIDTH < DW) ? CNT_WIDTH : DW;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 bready_q, bready_d;
  logic                 arvalid_q, arvalid_d;
  logic                 rready_q, rready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [AW-1:0]        base_q, base_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic [DW-1:0]        seed_q, seed_d;
  logic [DW-1:0]        idx_ext;
  logic [DW-1:0]        pattern;
  logic                 last;
  logic                 err_inc;

  always_comb begin
    idx_ext = '0;
    idx_ext[XW-1:0] = idx_q[XW-1:0];
  end

  assign pattern = seed_q ^ idx_ext;
  assign last    = (idx_q == n_q - CNT_WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    base_d    = base_q;
    addr_d    = addr_q;
    n_d       = n_q;
    idx_d     = idx_q;
    seed_d    = seed_q;
    err_inc   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = base_addr;
          addr_d    = base_addr;
          n_d       = num_words;
          seed_d    = seed;
          idx_d     = '0;
          err_cnt_d = '0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          if (num_words != '0) begin
            state_d   = S_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WR_REQ: begin
        // A channel whose valid is already low has handshaked in an earlier cycle.
        if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil_wready) wvalid_d = 1'b0;
        if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (m_axil_bvalid) begin
          bready_d = 1'b0;
          err_inc  = (m_axil_bresp != 2'b00);
          if (last) begin
            state_d   = S_RD_REQ;
            idx_d     = '0;
            addr_d    = base_q;
            arvalid_d = 1'b1;
          end else begin
            state_d   = S_WR_REQ;
            idx_d     = idx_q + CNT_WIDTH'(1);
            addr_d    = addr_q + AW'(SW);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (m_axil_rvalid) begin
          rready_d = 1'b0;
          err_inc  = (m_axil_rresp != 2'b00) || (m_axil_rdata != pattern);
          if (last) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_RD_REQ;
            idx_d     = idx_q + CNT_WIDTH'(1);
            addr_d    = addr_q + AW'(SW);
            arvalid_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_cnt_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
    end
    // Datapath registers are only meaningful once a test has been started.
    base_q <= base_d;
    addr_q <= addr_d;
    n_q    <= n_d;
    idx_q  <= idx_d;
    seed_q <= seed_d;
  end

`ifdef SVC_AXIL_MEM_TESTER_ERR_CAPTURE_EN
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic [DW-1:0] err_data_q, err_data_d;

  // Write-response failures record the pattern that was sent; read failures record rdata.
  always_comb begin
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    if (state_q == S_IDLE && start) begin
      err_addr_d = '0;
      err_data_d = '0;
    end else if (err_inc && (err_cnt_q == '0)) begin
      err_addr_d = addr_q;
      err_data_d = (state_q == S_WR_RESP) ? pattern : m_axil_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr_q <= '0;
      err_data_q <= '0;
    end else begin
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
    end
  end

  assign err_addr = err_addr_q;
  assign err_data = err_data_q;
`else
  assign err_addr = '0;
  assign err_data = '0;
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = pattern;
  assign m_axil_wstrb   = '1;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule
